// File: rtl/pll_phase_pkg.sv
// rtl/pll_phase_pkg.sv - shared state encoding, idle pin levels and clog2 for the PLL phase controller
package pll_phase_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STEP_LO = 3'd2,
        ST_STEP_HI = 3'd3,
        ST_SETTLE  = 3'd4,
        ST_DONE    = 3'd5,
        ST_ABORT   = 3'd6
    } state_t;

    localparam logic [1:0] IDLE_PHASESEL     = 2'd0;
    localparam logic       IDLE_PHASEDIR     = 1'b1;
    localparam logic       IDLE_PHASESTEP    = 1'b1;
    localparam logic       IDLE_PHASELOADREG = 1'b1;

    // Ceiling log2, never less than 1 so it can size a counter directly.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pll_phase_ctrl_lock_filter.sv
// rtl/pll_phase_ctrl_lock_filter.sv - 2-FF synchroniser and consecutive-high qualifier for PLL lock
module lock_filter
    import pll_phase_pkg::*;
#(
    parameter int LOCK_FILT = 256
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic pll_lock,
    output logic locked
);

    localparam int CW = clog2(LOCK_FILT + 1);

    logic          sync1;
    logic          sync2;
    logic          qual;
    logic [CW-1:0] cnt;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            qual  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= pll_lock;
            sync2 <= sync1;
            if (!sync2) begin
                qual <= 1'b0;
                cnt  <= '0;
            end else if (!qual) begin
                if (cnt == CW'(LOCK_FILT - 1)) begin
                    qual <= 1'b1;
                end
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Gating with sync2 drops locked in the very cycle the synchronised lock goes low.
    assign locked = qual & sync2;

endmodule

// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - dynamic phase-shift sequencer for PLL output channels with lock-loss abort
module pll_phase_ctrl
    import pll_phase_pkg::*;
#(
    parameter int NCHAN           = 4,
    parameter int CNTW            = 8,
    parameter int PHW             = 8,
    parameter int STEPS_PER_CYCLE = 16,
    parameter int PULSE_W         = 4,
    parameter int SETTLE          = 16,
    parameter int LOCK_FILT       = 256
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic                 pll_lock,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_chan,
    input  logic                 req_dir,
    input  logic [CNTW-1:0]      req_count,
    output logic                 done,
    output logic                 err,
    output logic                 locked,
    output logic [1:0]           phasesel,
    output logic                 phasedir,
    output logic                 phasestep,
    output logic                 phaseloadreg,
    output logic [NCHAN*PHW-1:0] phase_acc
);

    localparam int TMAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
    localparam int TW   = clog2(TMAX + 1);
    localparam logic [PHW-1:0] ACC_MAX = PHW'(STEPS_PER_CYCLE - 1);

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   tmr;
    logic [1:0]      chan_q;
    logic            dir_q;
    logic [CNTW-1:0] rem_q;
    logic [PHW-1:0]  acc [NCHAN];
    logic            locked_i;
    logic            handshake;
    logic            chan_bad;
    logic            tmr_done;
    logic            step_edge;
    logic            active;

    function automatic logic [PHW-1:0] wrap_step(input logic [PHW-1:0] v, input logic up);
        if (up) begin
            return (v == ACC_MAX) ? '0 : v + 1'b1;
        end
        return (v == '0) ? ACC_MAX : v - 1'b1;
    endfunction

    lock_filter #(
        .LOCK_FILT(LOCK_FILT)
    ) u_lock_filter (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .pll_lock(pll_lock),
        .locked  (locked_i)
    );

    assign locked    = locked_i;
    assign req_ready = (state == ST_IDLE) && locked_i;
    assign handshake = req_valid && req_ready;
    assign chan_bad  = ({1'b0, req_chan} >= 3'(NCHAN));
    assign tmr_done  = (tmr == '0);
    assign active    = (state == ST_SETUP) || (state == ST_STEP_LO) ||
                       (state == ST_STEP_HI) || (state == ST_SETTLE);
    assign step_edge = (state == ST_STEP_LO) && (state_nxt == ST_STEP_HI);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_nxt = chan_bad ? ST_ABORT : ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    state_nxt = (rem_q == '0) ? ST_SETTLE : ST_STEP_LO;
                end
            end
            ST_STEP_LO: begin
                if (tmr_done) begin
                    state_nxt = ST_STEP_HI;
                end
            end
            ST_STEP_HI: begin
                if (tmr_done) begin
                    state_nxt = (rem_q <= CNTW'(1)) ? ST_SETTLE : ST_STEP_LO;
                end
            end
            ST_SETTLE: begin
                if (tmr_done) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // Losing lock anywhere in the shift sequence overrides normal progress.
        if (active && !locked_i) begin
            state_nxt = ST_ABORT;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            tmr    <= '0;
            chan_q <= '0;
            dir_q  <= 1'b0;
            rem_q  <= '0;
        end else begin
            if (state_nxt != state) begin
                case (state_nxt)
                    ST_SETUP, ST_STEP_LO, ST_STEP_HI: tmr <= TW'(PULSE_W - 1);
                    ST_SETTLE:                        tmr <= TW'(SETTLE - 1);
                    default:                          tmr <= '0;
                endcase
            end else if (!tmr_done) begin
                tmr <= tmr - 1'b1;
            end

            if (handshake) begin
                chan_q <= req_chan;
                dir_q  <= req_dir;
                rem_q  <= req_count;
            end else if ((state == ST_STEP_HI) && (state_nxt == ST_STEP_LO)) begin
                rem_q <= rem_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (step_edge && (chan_q == i[1:0])) begin
                    acc[i] <= wrap_step(acc[i], dir_q);
                end
            end
        end
    end

    // Select and direction are held from SETUP through SETTLE so the PLL sees stable controls.
    always_comb begin
        phasesel     = IDLE_PHASESEL;
        phasedir     = IDLE_PHASEDIR;
        phasestep    = IDLE_PHASESTEP;
        phaseloadreg = IDLE_PHASELOADREG;
        case (state)
            ST_SETUP, ST_STEP_HI, ST_SETTLE: begin
                phasesel = chan_q;
                phasedir = dir_q;
            end
            ST_STEP_LO: begin
                phasesel  = chan_q;
                phasedir  = dir_q;
                phasestep = 1'b0;
            end
            default: ;
        endcase
    end

    assign done = (state == ST_DONE);
    assign err  = (state == ST_ABORT);

    for (genvar g = 0; g < NCHAN; g++) begin : g_acc
        assign phase_acc[g*PHW +: PHW] = acc[g];
    end

endmodule
